// File: rtl/mmio_monitor_pkg.sv
// Shared types and constants for the MMIO loopback monitor.
// Optional timestamping is enabled with MMIO_MONITOR_TIMESTAMP_EN.
package mmio_monitor_pkg;

  typedef enum logic [1:0] {
    LOOPBACK = 2'b00,
    EXTERNAL = 2'b01,
    FREEZE   = 2'b10
  } mmio_mode_t;

  localparam logic [1:0] MODE_LOOPBACK = 2'b00;
  localparam logic [1:0] MODE_EXTERNAL = 2'b01;
  localparam logic [1:0] MODE_FREEZE   = 2'b10;
  localparam logic [1:0] MODE_RSVD     = 2'b11;

  localparam int EVT_CNT_W  = 32;
  localparam int COAL_CNT_W = 16;
  localparam int TIME_W     = 32;

  // Channel index width, never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_monitor_event_fifo.sv
// Non-fall-through circular event FIFO with registered head outputs.
module mmio_event_fifo #(
  parameter int WIDTH     = 37,
  parameter int LOG_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] head
);
  localparam int DEPTH = 2 ** LOG_DEPTH;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LOG_DEPTH:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic empty, push_ok, pop_ok;
  logic [WIDTH-1:0] head_nxt;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[LOG_DEPTH] != rd_ptr[LOG_DEPTH]) &&
                   (wr_ptr[LOG_DEPTH-1:0] == rd_ptr[LOG_DEPTH-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign wr_nxt  = wr_ptr + {{LOG_DEPTH{1'b0}}, push_ok};
  assign rd_nxt  = rd_ptr + {{LOG_DEPTH{1'b0}}, pop_ok};

  // Bypass the write when it lands exactly at the next head slot.
  assign head_nxt = (push_ok && (wr_ptr[LOG_DEPTH-1:0] == rd_nxt[LOG_DEPTH-1:0]))
                  ? wdata : mem[rd_nxt[LOG_DEPTH-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[LOG_DEPTH-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      valid  <= (wr_nxt != rd_nxt);
      head   <= (wr_nxt != rd_nxt) ? head_nxt : '0;
    end
  end

endmodule

// File: rtl/mmio_loopback_monitor.sv
// MMIO source mux plus change-event capture into a FIFO.
// Define MMIO_MONITOR_TIMESTAMP_EN to add per-event cycle timestamps on evt_time_o.
module mmio_loopback_monitor
  import mmio_monitor_pkg::*;
#(
  parameter int CHANNELS   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LOG_DEPTH  = 4,
  localparam int CH_W      = ch_width(CHANNELS)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [CHANNELS-1:0][DATA_WIDTH-1:0] mmio_out_i,
  output logic [CHANNELS-1:0][DATA_WIDTH-1:0] mmio_in_o,
  input  logic [CHANNELS-1:0][1:0]            mode_i,
  input  logic [CHANNELS-1:0][DATA_WIDTH-1:0] ext_data_i,
  output logic                                evt_valid_o,
  input  logic                                evt_ready_i,
  output logic [CH_W-1:0]                     evt_channel_o,
  output logic [DATA_WIDTH-1:0]               evt_data_o,
`ifdef MMIO_MONITOR_TIMESTAMP_EN
  output logic [TIME_W-1:0]                   evt_time_o,
`endif
  output logic [EVT_CNT_W-1:0]                evt_count_o,
  output logic [COAL_CNT_W-1:0]               coalesce_count_o
);

  typedef struct packed {
    logic [CH_W-1:0]       channel;
    logic [DATA_WIDTH-1:0] data;
`ifdef MMIO_MONITOR_TIMESTAMP_EN
    logic [TIME_W-1:0]     stamp;
`endif
  } evt_t;

  logic [CHANNELS-1:0][DATA_WIDTH-1:0] prev_q, snap;
  logic [CHANNELS-1:0] pending, change, pushed, coal_hit;
  logic [CH_W-1:0] push_idx;
  logic push_fire, fifo_full;
  logic [5:0] coal_add;
  logic [COAL_CNT_W:0] coal_sum;
  evt_t wr_evt, head_evt;

`ifdef MMIO_MONITOR_TIMESTAMP_EN
  logic [TIME_W-1:0] cycle_q;
  logic [CHANNELS-1:0][TIME_W-1:0] snap_time;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cycle_q <= '0;
    else        cycle_q <= cycle_q + 1'b1;
  end
`endif

  // Per-channel source mux, change detect and pending snapshot.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign change[c]   = (mmio_out_i[c] != prev_q[c]);
    assign pushed[c]   = push_fire && (push_idx == CH_W'(c));
    assign coal_hit[c] = change[c] && pending[c] && !pushed[c];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mmio_in_o[c] <= '0;
        prev_q[c]    <= '0;
        snap[c]      <= '0;
        pending[c]   <= 1'b0;
      end else begin
        case (mmio_mode_t'(mode_i[c]))
          LOOPBACK: mmio_in_o[c] <= mmio_out_i[c];
          EXTERNAL: mmio_in_o[c] <= ext_data_i[c];
          default:  mmio_in_o[c] <= mmio_in_o[c];
        endcase
        prev_q[c] <= mmio_out_i[c];
        if (change[c]) begin
          pending[c] <= 1'b1;
          snap[c]    <= mmio_out_i[c];
        end else if (pushed[c]) begin
          pending[c] <= 1'b0;
        end
      end
    end

`ifdef MMIO_MONITOR_TIMESTAMP_EN
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         snap_time[c] <= '0;
      else if (change[c]) snap_time[c] <= cycle_q;
    end
`endif
  end

  // Lowest pending index wins.
  always_comb begin
    push_idx = '0;
    for (int c = CHANNELS - 1; c >= 0; c--)
      if (pending[c]) push_idx = CH_W'(c);
  end

  assign push_fire = (|pending) && (!fifo_full || (evt_valid_o && evt_ready_i));

  always_comb begin
    wr_evt         = '0;
    wr_evt.channel = push_idx;
    wr_evt.data    = snap[push_idx];
`ifdef MMIO_MONITOR_TIMESTAMP_EN
    wr_evt.stamp   = snap_time[push_idx];
`endif
  end

  // Several channels may coalesce in the same cycle.
  always_comb begin
    coal_add = '0;
    for (int c = 0; c < CHANNELS; c++) coal_add = coal_add + 6'(coal_hit[c]);
  end
  assign coal_sum = {1'b0, coalesce_count_o} + (COAL_CNT_W + 1)'(coal_add);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_count_o      <= '0;
      coalesce_count_o <= '0;
    end else begin
      if (push_fire) evt_count_o <= evt_count_o + 1'b1;
      coalesce_count_o <= coal_sum[COAL_CNT_W] ? '1 : coal_sum[COAL_CNT_W-1:0];
    end
  end

  mmio_event_fifo #(
    .WIDTH     ($bits(evt_t)),
    .LOG_DEPTH (LOG_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_fire),
    .wdata (wr_evt),
    .pop   (evt_ready_i),
    .full  (fifo_full),
    .valid (evt_valid_o),
    .head  (head_evt)
  );

  assign evt_channel_o = head_evt.channel;
  assign evt_data_o    = head_evt.data;
`ifdef MMIO_MONITOR_TIMESTAMP_EN
  assign evt_time_o    = head_evt.stamp;
`endif

endmodule

// File: tb/tb_mmio_loopback_monitor.sv
// Directed bench for mmio_loopback_monitor (small FIFO to exercise backpressure).
// Covers the timestamp path when MMIO_MONITOR_TIMESTAMP_EN is defined.
module tb_mmio_loopback_monitor;
  localparam int CH = 8;
  localparam int DW = 32;
  localparam int LD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CH-1:0][DW-1:0] mmio_out, mmio_in, ext_data;
  logic [CH-1:0][1:0]    mode;
  logic evt_valid, evt_ready;
  logic [2:0]  evt_channel;
  logic [DW-1:0] evt_data;
  logic [31:0] evt_count;
  logic [15:0] coal_count;
`ifdef MMIO_MONITOR_TIMESTAMP_EN
  logic [31:0] evt_time;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mmio_loopback_monitor #(.CHANNELS(CH), .DATA_WIDTH(DW), .LOG_DEPTH(LD)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mmio_out_i       (mmio_out),
    .mmio_in_o        (mmio_in),
    .mode_i           (mode),
    .ext_data_i       (ext_data),
    .evt_valid_o      (evt_valid),
    .evt_ready_i      (evt_ready),
    .evt_channel_o    (evt_channel),
    .evt_data_o       (evt_data),
`ifdef MMIO_MONITOR_TIMESTAMP_EN
    .evt_time_o       (evt_time),
`endif
    .evt_count_o      (evt_count),
    .coalesce_count_o (coal_count)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input int ch, input logic [31:0] data);
    chk({tag, "_vld"}, evt_valid, 1'b1);
    chk({tag, "_ch"}, evt_channel, ch);
    chk({tag, "_dat"}, evt_data, data);
  endtask

  initial begin
    mmio_out  = '0;
    ext_data  = '0;
    mode      = '0;
    evt_ready = 1'b0;
    #1;
    chk("rst_vld", evt_valid, 1'b0);
    chk("rst_in", mmio_in, '0);
    chk("rst_cnt", evt_count, 0);
    chk("rst_coal", coal_count, 0);
    chk("rst_head", {evt_channel, evt_data}, '0);
    #11 rst_n = 1'b1;
    tick(); tick(); tick();

    // Loopback latency and single event latency
    mmio_out[3] = 32'h12345678;
    tick();
    chk("lb_in3", mmio_in[3], 32'h12345678);
    chk("lb_vld_early", evt_valid, 1'b0);
    tick();
    head("lb_evt", 3, 32'h12345678);
    chk("lb_cnt", evt_count, 1);
    evt_ready = 1'b1;
    tick();
    chk("lb_pop", evt_valid, 1'b0);

    // Simultaneous changes drain in ascending order
    mmio_out[6] = 32'h66; mmio_out[1] = 32'h11; mmio_out[4] = 32'h44;
    tick();
    chk("sim_vld_early", evt_valid, 1'b0);
    tick(); head("sim_1", 1, 32'h11);
    tick(); head("sim_4", 4, 32'h44);
    tick(); head("sim_6", 6, 32'h66);
    tick();
    chk("sim_empty", evt_valid, 1'b0);
    chk("sim_cnt", evt_count, 4);
    evt_ready = 1'b0;

    // Backpressure: 4-deep FIFO, 5 changes, then coalesce on channel 4
    for (int c = 0; c < 5; c++) mmio_out[c] = 32'hA0 + c;
    repeat (6) tick();
    head("bp_full", 0, 32'hA0);
    chk("bp_cnt", evt_count, 8);
    chk("bp_coal0", coal_count, 0);
    mmio_out[4] = 32'hB1; tick();
    mmio_out[4] = 32'hB2; tick();
    tick();
    chk("bp_coal2", coal_count, 2);
    chk("bp_cnt_hold", evt_count, 8);
    evt_ready = 1'b1;
    tick(); head("bp_1", 1, 32'hA1);
    tick(); head("bp_2", 2, 32'hA2);
    tick(); head("bp_3", 3, 32'hA3);
    tick(); head("bp_4", 4, 32'hB2);
    tick();
    chk("bp_empty", evt_valid, 1'b0);
    chk("bp_cnt_end", evt_count, 9);
    evt_ready = 1'b0;

    // Source modes
    chk("md_lb2", mmio_in[2], 32'hA2);
    mode[2] = 2'b01; ext_data[2] = 32'hDEADBEEF;
    tick();
    chk("md_ext", mmio_in[2], 32'hDEADBEEF);
    mode[2] = 2'b10; ext_data[2] = 32'h11111111;
    tick(); tick();
    chk("md_frz", mmio_in[2], 32'hDEADBEEF);
    mode[2] = 2'b11; ext_data[2] = 32'h22222222;
    tick();
    chk("md_rsvd", mmio_in[2], 32'hDEADBEEF);
    chk("md_lb3", mmio_in[3], 32'hA3);

    // Asynchronous reset with 3 queued and 2 pending
    for (int c = 0; c < 5; c++) mmio_out[c] = 32'hC0 + c;
    tick(); tick(); tick(); tick();
    chk("ar_pre_cnt", evt_count, 12);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_vld", evt_valid, 1'b0);
    chk("ar_in", mmio_in, '0);
    chk("ar_cnt", evt_count, 0);
    chk("ar_coal", coal_count, 0);
    mmio_out = '0; mode = '0; ext_data = '0; evt_ready = 1'b1;
    #5 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("ar_stale", evt_valid, 1'b0);
    end
    chk("ar_cnt_post", evt_count, 0);

`ifdef MMIO_MONITOR_TIMESTAMP_EN
    @(negedge clk) rst_n = 1'b0;
    #2 rst_n = 1'b1;
    repeat (10) tick();
    mmio_out[5] = 32'h55;
    tick(); tick();
    head("ts_evt", 5, 32'h55);
    chk("ts_time", evt_time, 10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
